// File: rtl/mem_resp.sv
// Memory-side responder for the test bus: auto-clears after reset, serves byte reads/writes,
// flags protocol errors and counts accesses. Optional parity via `MEM_RESP_PARITY_EN.
module mem_resp #(
  parameter int                ADDR_W   = 5,
  parameter int                DATA_W   = 8,
  parameter logic [DATA_W-1:0] INIT_VAL = '0,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              ready,
  output logic              rd_valid,
  output logic              err,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic              parity_err
);
  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {INIT, RUN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic              init_we, run_wr, run_rd, proto_err;
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    init_we   = 1'b0;
    run_wr    = 1'b0;
    run_rd    = 1'b0;
    proto_err = 1'b0;
    case (state)
      INIT: begin
        init_we   = 1'b1;
        ptr_nxt   = ptr + 1'b1;
        proto_err = read | write;
        if (ptr == {ADDR_W{1'b1}}) state_nxt = RUN;
      end
      RUN: begin
        run_wr    = write & ~read;
        run_rd    = read & ~write;
        proto_err = read & write;
      end
      default: state_nxt = INIT;
    endcase
  end

  assign ready = (state == RUN);

  // Clear and run-time writes share one port; reset edge performs no array write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (init_we)     mem[ptr]  <= INIT_VAL;
      else if (run_wr) mem[addr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
      rd_valid <= 1'b0;
      err      <= 1'b0;
      wr_cnt   <= '0;
      rd_cnt   <= '0;
    end else begin
      rd_valid <= run_rd;
      if (run_rd)                    data_out <= mem[addr];
      if (proto_err)                 err      <= 1'b1;
      if (run_wr && wr_cnt != '1)    wr_cnt   <= wr_cnt + 1'b1;
      if (run_rd && rd_cnt != '1)    rd_cnt   <= rd_cnt + 1'b1;
    end
  end

`ifdef MEM_RESP_PARITY_EN
  // Even-parity bit per word, kept beside the data array.
  logic [DEPTH-1:0] par_mem;
  logic             par_err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (init_we)     par_mem[ptr]  <= ^INIT_VAL;
      else if (run_wr) par_mem[addr] <= ^data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      par_err_q <= 1'b0;
    else if (run_rd && ((^mem[addr]) != par_mem[addr]))
      par_err_q <= 1'b1;
  end

  assign parity_err = par_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
